// File: rtl/conv1d_mac_engine_if.sv
// conv1d_mac_engine_if: job control, scratchpad read ports and psum output
// handshake of the 1-D convolution MAC engine.
//   master : job issuer / scratchpads / psum stage side
//   slave  : the MAC engine itself
interface conv1d_mac_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 20
);
  // job control
  logic                          start;
  logic [ADDR_WIDTH:0]           ifmap_len;
  logic [ADDR_WIDTH:0]           filt_len;
  logic [ADDR_WIDTH-1:0]         stride;
  // scratchpad reads (combinational data return)
  logic [ADDR_WIDTH-1:0]         if_raddr;
  logic signed [DATA_WIDTH-1:0]  if_dout;
  logic [ADDR_WIDTH-1:0]         f_raddr;
  logic signed [DATA_WIDTH-1:0]  f_dout;
  // psum output
  logic signed [ACC_WIDTH-1:0]   out_data;
  logic                          out_valid;
  logic                          out_ready;
  // status
  logic                          busy;
  logic                          done;

  modport master (
    output start, ifmap_len, filt_len, stride, if_dout, f_dout, out_ready,
    input  if_raddr, f_raddr, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, ifmap_len, filt_len, stride, if_dout, f_dout, out_ready,
    output if_raddr, f_raddr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/conv1d_mac_engine.sv
// conv1d_mac_engine: walks a filter window across an ifmap held in two
// combinational-read scratchpads, multiply-accumulates one window per output
// and hands each signed partial sum downstream over valid/ready.
// Optional feature macro: SATURATE_EN -- when defined, every accumulate step
// clamps to the signed ACC_WIDTH range; otherwise accumulation wraps.
module conv1d_mac_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  conv1d_mac_engine_if.slave   bus
);

  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUT    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state, state_next;

  // job parameters captured at start
  logic [LW-1:0] ifmap_len_q;
  logic [LW-1:0] filt_len_q;
  logic [LW-1:0] stride_q;

  // window position and tap index
  logic [LW-1:0] base;
  logic [LW-1:0] k;

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;

  logic [LW-1:0]         base_step;
  logic [LW:0]           window_end;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  job_empty;
  logic                  last_tap;

  // a job with no complete window goes straight to FINISH
  assign job_empty   = (bus.filt_len == '0) || (bus.ifmap_len < bus.filt_len);
  assign last_tap    = (k == filt_len_q - LW'(1));
  assign base_step   = base + stride_q;
  // one extra bit so base + filt_len never wraps before the bound test
  assign window_end  = {1'b0, base_step} + {1'b0, filt_len_q};
  assign rd_addr     = base[ADDR_WIDTH-1:0] + k[ADDR_WIDTH-1:0];
  assign product     = bus.if_dout * bus.f_dout;
  assign product_ext = ACC_WIDTH'(product);

`ifdef SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam int AW1 = ACC_WIDTH + 1;
  logic signed [ACC_WIDTH:0] sum_wide;

  // clamped accumulate: overflow shows as disagreement of the top two sum bits
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sum_wide = AW1'(acc) + AW1'(product_ext);
    acc_sum  = sum_wide[ACC_WIDTH-1:0];
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
      acc_sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end
`else
  // wrapping accumulate, modulo 2^ACC_WIDTH
  assign acc_sum = acc + product_ext;
`endif

  // state register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = job_empty ? FINISH : ACCUM;
      ACCUM:   if (last_tap) state_next = OUT;
      OUT:     if (bus.out_ready)
                 state_next = (window_end > {1'b0, ifmap_len_q}) ? FINISH : ACCUM;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // datapath: parameter capture, window/tap counters and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these are plain registers, not a memory array, so all of them are cleared on reset.
      ifmap_len_q <= '0;
      filt_len_q  <= '0;
      stride_q    <= '0;
      base        <= '0;
      k           <= '0;
      acc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ifmap_len_q <= bus.ifmap_len;
            filt_len_q  <= bus.filt_len;
            stride_q    <= (bus.stride == '0) ? LW'(1) : {1'b0, bus.stride};
            base        <= '0;
            k           <= '0;
          end
        end
        ACCUM: begin
          acc <= (k == '0) ? product_ext : acc_sum;
          k   <= k + LW'(1);
        end
        OUT: begin
          if (bus.out_ready) begin
            base <= base_step;
            k    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decoded from state; addresses idle at zero outside ACCUM
  always_comb begin
    bus.if_raddr  = '0;
    bus.f_raddr   = '0;
    bus.out_data  = '0;
    bus.out_valid = 1'b0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    case (state)
      ACCUM: begin
        bus.if_raddr = rd_addr;
        bus.f_raddr  = k[ADDR_WIDTH-1:0];
      end
      OUT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc;
      end
      FINISH:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
